// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Receive-side monitor for a multiplexed 7-segment display bus. It samples the
// active-low segment lines and digit enables, waits until a digit's pattern
// has been stable for STABLE_CYCLES samples, then maps the segment pattern
// back to a hex nibble. When every digit position has been committed since
// the last frame, it produces a one-cycle frame_valid pulse.
//
// Parameters
//   DIGITS        number of multiplexed digit positions (1..8)
//   STABLE_CYCLES identical samples required before a commit (2..15)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   seg[7:0]     active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//   an           active-low digit enables, exactly one low selects a digit
//   digits       decoded nibble per digit, digit i at [4i+3:4i]
//   dp_out       decimal point per digit, active-high
//   invalid      1 = last committed pattern of digit i was not a hex code
//   frame_valid  one-cycle pulse when all positions have been committed
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     dp_out,
   output logic [DIGITS-1:0]     invalid,
   output logic                  frame_valid
);

   localparam int         IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

   // Inverse hex-to-segment map. Returns {no_match, value}; value is 0 on no match.
   function automatic logic [4:0] decode_seg(input logic [6:0] segs);
      logic [4:0] res;
      case (segs)
         7'h3F:   res = 5'h00;
         7'h06:   res = 5'h01;
         7'h5B:   res = 5'h02;
         7'h4F:   res = 5'h03;
         7'h66:   res = 5'h04;
         7'h6D:   res = 5'h05;
         7'h7D:   res = 5'h06;
         7'h07:   res = 5'h07;
         7'h7F:   res = 5'h08;
         7'h6F:   res = 5'h09;
         7'h77:   res = 5'h0A;
         7'h7C:   res = 5'h0B;
         7'h39:   res = 5'h0C;
         7'h5E:   res = 5'h0D;
         7'h79:   res = 5'h0E;
         7'h71:   res = 5'h0F;
         default: res = 5'h10;
      endcase
      return res;
   endfunction

   // input sample stage and the sample before it, for change detection
   logic [7:0]        r_s_seg;
   logic [DIGITS-1:0] r_s_an;
   logic [7:0]        r_p_seg;
   logic [DIGITS-1:0] r_p_an;
   logic [3:0]        r_cnt;
   logic [DIGITS-1:0] r_seen;

   logic [4:0]          w_low_cnt;
   logic [IDX_W-1:0]    w_sel_idx;
   logic                w_sel_ok;
   logic                w_changed;
   logic [3:0]          w_cnt_next;
   logic                w_commit;
   logic [4:0]          w_dec;
   logic [DIGITS-1:0]   w_seen_set;
   logic                w_frame_done;
   logic [4*DIGITS-1:0] w_digits_next;
   logic [DIGITS-1:0]   w_dp_next;
   logic [DIGITS-1:0]   w_inv_next;

   // Locate the single low enable; more than one low (or none) is not a selection.
   always_comb begin
      w_low_cnt = 5'd0;
      w_sel_idx = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!r_s_an[k]) begin
            w_low_cnt = w_low_cnt + 5'd1;
            w_sel_idx = IDX_W'(k);
         end else begin
            w_low_cnt = w_low_cnt;
         end
      end
      w_sel_ok = (w_low_cnt == 5'd1);
   end

   // Qualification counter and the commit strobe (fires once, on reaching CNT_MAX).
   always_comb begin
      w_changed = ({r_s_an, r_s_seg} != {r_p_an, r_p_seg});
      if (!w_sel_ok) begin
         w_cnt_next = 4'd0;
      end else if (w_changed) begin
         w_cnt_next = 4'd1;
      end else if (r_cnt == CNT_MAX) begin
         w_cnt_next = r_cnt;
      end else begin
         w_cnt_next = r_cnt + 4'd1;
      end
      w_commit = (w_cnt_next == CNT_MAX) && (r_cnt != CNT_MAX);
      w_dec    = decode_seg(~r_s_seg[6:0]);
   end

   // Next values of the per-digit outputs and the frame accumulator.
   always_comb begin
      w_digits_next = digits;
      w_dp_next     = dp_out;
      w_inv_next    = invalid;
      w_seen_set    = r_seen;
      for (int k = 0; k < DIGITS; k++) begin
         if (w_commit && (w_sel_idx == IDX_W'(k))) begin
            w_digits_next[4*k +: 4] = w_dec[3:0];
            w_dp_next[k]            = ~r_s_seg[7];
            w_inv_next[k]           = w_dec[4];
            w_seen_set[k]           = 1'b1;
         end else begin
            w_digits_next[4*k +: 4] = digits[4*k +: 4];
            w_dp_next[k]            = dp_out[k];
            w_inv_next[k]           = invalid[k];
            w_seen_set[k]           = r_seen[k];
         end
      end
      w_frame_done = w_commit && (&w_seen_set);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s_seg     <= 8'hFF;
         r_s_an      <= '1;
         r_p_seg     <= 8'hFF;
         r_p_an      <= '1;
         r_cnt       <= 4'd0;
         r_seen      <= '0;
         digits      <= '0;
         dp_out      <= '0;
         invalid     <= '0;
         frame_valid <= 1'b0;
      end else begin
         r_s_seg     <= seg;
         r_s_an      <= an;
         r_p_seg     <= r_s_seg;
         r_p_an      <= r_s_an;
         r_cnt       <= w_cnt_next;
         digits      <= w_digits_next;
         dp_out      <= w_dp_next;
         invalid     <= w_inv_next;
         frame_valid <= w_frame_done;
         // the completing commit starts a fresh frame
         if (w_frame_done) begin
            r_seen <= '0;
         end else begin
            r_seen <= w_seen_set;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

   localparam int D  = 8;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    seg;
   logic [D-1:0]  an;
   logic [4*D-1:0] digits;
   logic [D-1:0]  dp_out;
   logic [D-1:0]  invalid;
   logic          frame_valid;

   seg_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .seg(seg), .an(an),
      .digits(digits), .dp_out(dp_out), .invalid(invalid), .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] dig;
      logic [7:0]  dp;
      logic [7:0]  inv;
      logic        fv;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   edge_cnt = 0;

   // reference model state
   logic [31:0] m_dig = '0;
   logic [7:0]  m_dp = '0, m_inv = '0, m_seen = '0;
   logic [31:0] shown_dig = '0;
   logic [7:0]  shown_dp = '0, shown_inv = '0;
   logic [15:0] last_pat = 16'hFFFF;
   int          run = 0;

   logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_cnt);
      end
   endtask

   function automatic logic [7:0] pat(input int v, input logic dp);
      logic [7:0] p;
      p = ~{dp, codes[v]};
      return p;
   endfunction

   // model a commit of sample s on digit idx; outputs expected one edge later
   task automatic model_commit(input int idx, input logic [7:0] s);
      exp_t e;
      logic [3:0] val;
      logic       bad;
      val = 4'h0;
      bad = 1'b1;
      for (int v = 0; v < 16; v++) begin
         if (codes[v] == ~s[6:0]) begin
            val = 4'(v);
            bad = 1'b0;
         end
      end
      m_dig[4*idx +: 4] = val;
      m_dp[idx]   = ~s[7];
      m_inv[idx]  = bad;
      m_seen[idx] = 1'b1;
      e.fv = (m_seen == 8'hFF);
      if (e.fv) m_seen = '0;
      e.cyc = edge_cnt + 1;
      e.dig = m_dig;
      e.dp  = m_dp;
      e.inv = m_inv;
      q.push_back(e);
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] s, input int n);
      int lows;
      int idx;
      an  = a;
      seg = s;
      lows = 0;
      idx = 0;
      for (int k = 0; k < D; k++) begin
         if (!a[k]) begin
            lows++;
            idx = k;
         end
      end
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         edge_cnt++;
         if (lows != 1) run = 0;
         else if ({a, s} == last_pat) run++;
         else run = 1;
         last_pat = {a, s};
         if (lows == 1 && run == SC) model_commit(idx, s);
         #1;
      end
   endtask

   task automatic scan(input logic [31:0] vals, input int first, input int last,
                       input int hold, input logic [7:0] dpm);
      for (int i = first; i <= last; i++)
         drive(~(8'h01 << i), pat(int'(vals[4*i +: 4]), dpm[i]), hold);
   endtask

   task automatic do_reset_mid();
      an  = '1;
      seg = 8'hFF;
      rst = 1'b1;
      #1;
      check_eq("rst_digits", digits, 32'h0);
      check_eq("rst_dp", dp_out, 8'h0);
      check_eq("rst_inv", invalid, 8'h0);
      check_eq("rst_fv", frame_valid, 1'b0);
      check_eq("rst_queue", q.size(), 0);
      q.delete();
      m_dig = '0; m_dp = '0; m_inv = '0; m_seen = '0;
      shown_dig = '0; shown_dp = '0; shown_inv = '0;
      last_pat = 16'hFFFF;
      run = 0;
      @(posedge clk);
      edge_cnt++;
      #1 rst = 1'b0;
   endtask

   // scoreboard: pop expected snapshots at their edge, otherwise outputs must hold
   always @(negedge clk) begin
      exp_t e;
      logic fv_exp;
      if (!rst) begin
         if (q.size() > 0 && q[0].cyc < edge_cnt) begin
            check_eq("missed_commit_edge", edge_cnt, q[0].cyc);
            void'(q.pop_front());
         end
         fv_exp = 1'b0;
         if (q.size() > 0 && q[0].cyc == edge_cnt) begin
            e = q.pop_front();
            shown_dig = e.dig;
            shown_dp  = e.dp;
            shown_inv = e.inv;
            fv_exp    = e.fv;
         end
         check_eq("digits", digits, shown_dig);
         check_eq("dp_out", dp_out, shown_dp);
         check_eq("invalid", invalid, shown_inv);
         check_eq("frame_valid", frame_valid, fv_exp);
      end
   end

   initial begin
      rst = 1'b1;
      an  = '1;
      seg = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      check_eq("init_digits", digits, 32'h0);
      check_eq("init_fv", frame_valid, 1'b0);
      rst = 1'b0;

      // single digit 0 on position 0
      drive(8'hFE, 8'hC0, 6);
      drive(8'hFF, 8'hFF, 2);

      // two full scans, dp on digit 3, direct digit-to-digit transitions
      scan(32'h76543210, 0, 7, 6, 8'h08);
      scan(32'h76543210, 0, 7, 6, 8'h08);
      drive(8'hFF, 8'hFF, 2);

      // unmatched pattern on digit 2, then a valid 'A'
      drive(8'hFB, 8'hFE, 6);
      drive(8'hFF, 8'hFF, 1);
      drive(8'hFB, 8'h88, 6);

      // short glitch then a just-long-enough pattern
      drive(8'hFD, pat(0, 1'b0), 3);
      drive(8'hFD, pat(9, 1'b0), 4);
      drive(8'hFF, 8'hFF, 2);

      // two enables low: never a selection
      drive(8'hFC, pat(5, 1'b0), 10);

      // partial scan, re-commit digit 0, complete with digit 7
      scan(32'h0FEDCBA9, 0, 6, 5, 8'h00);
      drive(8'hFE, pat(14, 1'b1), 5);
      drive(8'h7F, pat(3, 1'b0), 5);
      drive(8'hFF, 8'hFF, 2);

      // reset in the middle of a frame, then a full scan
      scan(32'h13579BDF, 0, 4, 5, 8'h00);
      drive(8'hFF, 8'hFF, 2);
      do_reset_mid();
      scan(32'hFEDCBA98, 0, 7, 5, 8'hA5);
      drive(8'hFF, 8'hFF, 2);

      // random mix of enables, patterns and hold lengths
      for (int r = 0; r < 40; r++) begin
         logic [7:0] a;
         logic [7:0] s;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 8) a = ~(8'h01 << sel);
         else if (sel == 8) a = 8'hFF;
         else a = 8'hF3;
         if ($urandom_range(0, 3) == 0) s = 8'($urandom_range(0, 255));
         else s = pat($urandom_range(0, 15), 1'($urandom_range(0, 1)));
         drive(a, s, $urandom_range(1, 7));
      end
      drive(8'hFF, 8'hFF, 8);

      check_eq("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
